// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the pipelined adder/subtractor.
// Pure declarations: no latency or flow-control behaviour of its own.
package adder_pkg;

    localparam int DEF_N    = 16;
    localparam int DEF_LANE = 4;

    // One carry-chain slice is resolved per pipeline stage.
    function automatic int num_stages(input int n, input int lane);
        return n / lane;
    endfunction

    typedef struct packed {
        logic v;
        logic z;
    } flags_t;

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle between producer, adder_pipe and consumer.
// No logic: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface adder_pipe_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         V;
    logic         Z;

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, Sum, Cout, V, Z
    );

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, V, Z
    );
endinterface

// File: rtl/adder_lane.sv
// Combinational W-bit slice adder with carry in/out.
// Zero latency; no flow control.
module adder_lane #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/adder_pipe.sv
// Pipelined N-bit add/sub, one LANE-bit carry slice per stage, with Cout/V/Z flags.
// Latency N/LANE cycles; whole pipe stalls together when the output is held, in_ready = advance.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int LANE = DEF_LANE
) (
    input  logic        clk,
    input  logic        n_reset,
    adder_pipe_if.slave io
);
    localparam int STAGES = num_stages(N, LANE);

    // Per-stage record: sum holds the slices resolved so far, a/b carry the skewed operands.
    typedef struct packed {
        logic         vld;
        logic         cy;
        logic [N-1:0] sum;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } stage_t;

    stage_t                           in_rec;
    stage_t [STAGES-1:0]              lane_in;
    stage_t [STAGES-1:0]              st_d;
    stage_t [STAGES-1:0]              st_q;
    logic   [STAGES-1:0][LANE-1:0]    lane_s;
    logic   [STAGES-1:0]              lane_co;
    flags_t                           flags_d;
    flags_t                           flags_q;
    logic                             advance;

    assign advance     = io.out_ready || !st_q[STAGES-1].vld;
    assign io.in_ready = advance;

    always_comb begin
        in_rec     = '0;
        in_rec.vld = io.in_valid;
        in_rec.cy  = io.Cin ^ io.sub;
        in_rec.a   = io.A;
        in_rec.b   = io.sub ? ~io.B : io.B;
    end

    always_comb begin
        lane_in    = '0;
        lane_in[0] = in_rec;
        for (int k = 1; k < STAGES; k++) begin
            lane_in[k] = st_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_lane #(.W(LANE)) u_lane (
            .a  (lane_in[k].a[k*LANE +: LANE]),
            .b  (lane_in[k].b[k*LANE +: LANE]),
            .ci (lane_in[k].cy),
            .s  (lane_s[k]),
            .co (lane_co[k])
        );
    end

    always_comb begin
        st_d = lane_in;
        for (int k = 0; k < STAGES; k++) begin
            st_d[k].sum[k*LANE +: LANE] = lane_s[k];
            st_d[k].cy                  = lane_co[k];
        end
    end

    // Flags need the full aligned sum, so they are formed as the last slice completes.
    always_comb begin
        flags_d   = '0;
        flags_d.v = (st_d[STAGES-1].a[N-1] == st_d[STAGES-1].b[N-1]) &&
                    (st_d[STAGES-1].sum[N-1] != st_d[STAGES-1].a[N-1]);
        flags_d.z = (st_d[STAGES-1].sum == '0);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            st_q    <= '0;
            flags_q <= '0;
        end else if (advance) begin
            st_q    <= st_d;
            flags_q <= flags_d;
        end
    end

    assign io.out_valid = st_q[STAGES-1].vld;
    assign io.Sum       = st_q[STAGES-1].sum;
    assign io.Cout      = st_q[STAGES-1].cy;
    assign io.V         = flags_q.v;
    assign io.Z         = flags_q.z;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (N=16, LANE=4): directed corner cases plus randomized traffic
// scored against an integer-arithmetic reference model.
module tb_adder_pipe;
    localparam int N      = 16;
    localparam int LANE   = 4;
    localparam int STAGES = N / LANE;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    adder_pipe_if #(.N(N)) io ();

    adder_pipe #(.N(N), .LANE(LANE)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .io      (io.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        v;
        logic        z;
    } res_t;

    // Reference: plain integer add/sub; V from signed range, Cout from unsigned range.
    function automatic res_t ref_op(input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic sub);
        res_t r;
        int ua, ub, sa, sb, ci, r_u, r_s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = cin ? 1 : 0;
        if (!sub) begin
            r_u    = ua + ub + ci;
            r_s    = sa + sb + ci;
            r.cout = (r_u > 65535);
        end else begin
            r_u    = ua - ub - ci;
            r_s    = sa - sb - ci;
            r.cout = (r_u >= 0);
        end
        r.sum = r_u[15:0];
        r.v   = (r_s > 32767) || (r_s < -32768);
        r.z   = (r.sum == 16'h0000);
        return r;
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        logic seen;
        n_reset      = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        io.A = '0; io.B = '0; io.Cin = 1'b0; io.sub = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({io.out_valid, io.Sum, io.Cout, io.V, io.Z} !== 20'h0)
            $display("FAIL reset_state: got vld=%b sum=%h c=%b v=%b z=%b exp all zero",
                     io.out_valid, io.Sum, io.Cout, io.V, io.Z);
        else n_pass++;
        n_reset = 1'b1;
        #1;
        n_checks++;
        if (io.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", io.in_ready);
        else n_pass++;
        // Fill the pipe so a result is in flight, then reset between edges.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            io.in_valid = 1'b1;
            io.A = 16'($urandom) | 16'h0100;
            io.B = 16'($urandom);
        end
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        n_checks++;
        if (io.out_valid !== 1'b0 || io.Sum !== 16'h0)
            $display("FAIL reset_midstream: got vld=%b sum=%h exp vld=0 sum=0000", io.out_valid, io.Sum);
        else n_pass++;
        io.in_valid = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= io.out_valid;
        end
        n_checks++;
        if (seen !== 1'b0 || io.in_ready !== 1'b1)
            $display("FAIL reset_no_stale: got out_valid_seen=%b in_ready=%b exp 0/1", seen, io.in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] ta [4];
        logic [15:0] tb [4];
        logic [15:0] ts [4];
        logic        tc [4];
        logic        tsub [4];
        logic [2:0]  tf [4];
        logic        early;
        ta[0] = 16'hFFFF; tb[0] = 16'h0001; tc[0] = 0; tsub[0] = 0; ts[0] = 16'h0000; tf[0] = 3'b101;
        ta[1] = 16'h7FFF; tb[1] = 16'h0001; tc[1] = 0; tsub[1] = 0; ts[1] = 16'h8000; tf[1] = 3'b010;
        ta[2] = 16'h8000; tb[2] = 16'h0001; tc[2] = 0; tsub[2] = 1; ts[2] = 16'h7FFF; tf[2] = 3'b110;
        ta[3] = 16'h0003; tb[3] = 16'h0005; tc[3] = 1; tsub[3] = 1; ts[3] = 16'hFFFD; tf[3] = 3'b000;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            io.A = ta[t]; io.B = tb[t]; io.Cin = tc[t]; io.sub = tsub[t];
            io.in_valid  = 1'b1;
            io.out_ready = 1'b1;
            @(negedge clk);
            io.in_valid = 1'b0;
            early = 1'b0;
            repeat (STAGES - 1) begin
                early |= io.out_valid;
                @(negedge clk);
            end
            n_checks++;
            if (early !== 1'b0 || io.out_valid !== 1'b1)
                $display("FAIL latency_dir%0d: got early=%b vld=%b exp early=0 vld=1", t, early, io.out_valid);
            else n_pass++;
            n_checks++;
            if ({io.Sum, io.Cout, io.V, io.Z} !== {ts[t], tf[t]})
                $display("FAIL result_dir%0d: got sum=%h cvz=%b%b%b exp sum=%h cvz=%b",
                         t, io.Sum, io.Cout, io.V, io.Z, ts[t], tf[t]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a_arr [8];
        res_t        e;
        io.out_ready = 1'b1;
        io.B = 16'h1111; io.Cin = 1'b0; io.sub = 1'b0;
        for (int m = 0; m < 12; m++) begin
            if (m < 8) begin
                a_arr[m]    = 16'(32'h1000 + m * 32'h0F0F);
                io.A        = a_arr[m];
                io.in_valid = 1'b1;
            end else begin
                io.in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (io.out_valid !== (m >= STAGES))
                $display("FAIL b2b_valid%0d: got %b exp %b", m, io.out_valid, (m >= STAGES));
            else n_pass++;
            if (m >= STAGES) begin
                e = ref_op(a_arr[m-STAGES], 16'h1111, 1'b0, 1'b0);
                n_checks++;
                if ({io.Sum, io.Cout, io.V, io.Z} !== {e.sum, e.cout, e.v, e.z})
                    $display("FAIL b2b_result%0d: got sum=%h cvz=%b%b%b exp sum=%h cvz=%b%b%b",
                             m, io.Sum, io.Cout, io.V, io.Z, e.sum, e.cout, e.v, e.z);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        res_t        q[$];
        res_t        e;
        logic [15:0] held;
        int          accepted = 0;
        int          popped   = 0;
        for (int c = 0; c < 80 && !(accepted == 12 && popped == 12); c++) begin
            io.out_ready = !(c >= 4 && c <= 8);
            io.in_valid  = (accepted < 12);
            io.A = pick_operand(); io.B = pick_operand();
            io.Cin = 1'($urandom); io.sub = 1'($urandom);
            #1;
            if (c >= 4 && c <= 8) begin
                if (c == 4) held = io.Sum;
                n_checks++;
                if (io.in_ready !== 1'b0 || io.out_valid !== 1'b1 || io.Sum !== held)
                    $display("FAIL bp_stall%0d: got rdy=%b vld=%b sum=%h exp rdy=0 vld=1 sum=%h",
                             c, io.in_ready, io.out_valid, io.Sum, held);
                else n_pass++;
            end
            if (io.out_valid && io.out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL bp_extra: got unexpected result sum=%h exp none", io.Sum);
                end else begin
                    e = q.pop_front();
                    if ({io.Sum, io.Cout, io.V, io.Z} !== {e.sum, e.cout, e.v, e.z})
                        $display("FAIL bp_result%0d: got sum=%h cvz=%b%b%b exp sum=%h cvz=%b%b%b",
                                 popped, io.Sum, io.Cout, io.V, io.Z, e.sum, e.cout, e.v, e.z);
                    else n_pass++;
                end
                popped++;
            end
            if (io.in_valid && io.in_ready) begin
                q.push_back(ref_op(io.A, io.B, io.Cin, io.sub));
                accepted++;
            end
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        n_checks++;
        if (popped !== 12 || q.size() !== 0)
            $display("FAIL bp_count: got popped=%0d pending=%0d exp 12/0", popped, q.size());
        else n_pass++;
    endtask

    task automatic test_random(input int n_ops);
        res_t        q[$];
        res_t        e;
        logic        prev_hold = 1'b0;
        logic [15:0] prev_sum  = '0;
        int          accepted  = 0;
        int          popped    = 0;
        int          bad       = 0;
        for (int c = 0; c < 60000 && !(accepted == n_ops && q.size() == 0); c++) begin
            io.in_valid  = (accepted < n_ops) && ($urandom_range(0, 3) != 0);
            io.out_ready = ($urandom_range(0, 3) != 0);
            io.A = pick_operand(); io.B = pick_operand();
            io.Cin = 1'($urandom); io.sub = 1'($urandom);
            #1;
            n_checks++;
            if (io.in_ready !== (io.out_ready || !io.out_valid)) begin
                bad++;
                if (bad < 10) $display("FAIL rnd_in_ready%0d: got %b exp %b", c, io.in_ready,
                                       (io.out_ready || !io.out_valid));
            end else n_pass++;
            if (prev_hold) begin
                n_checks++;
                if (io.out_valid !== 1'b1 || io.Sum !== prev_sum) begin
                    bad++;
                    if (bad < 10) $display("FAIL rnd_hold%0d: got vld=%b sum=%h exp vld=1 sum=%h",
                                           c, io.out_valid, io.Sum, prev_sum);
                end else n_pass++;
            end
            prev_hold = io.out_valid && !io.out_ready;
            prev_sum  = io.Sum;
            if (io.out_valid && io.out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    bad++;
                    if (bad < 10) $display("FAIL rnd_extra%0d: got sum=%h exp no result", c, io.Sum);
                end else begin
                    e = q.pop_front();
                    if ({io.Sum, io.Cout, io.V, io.Z} !== {e.sum, e.cout, e.v, e.z}) begin
                        bad++;
                        if (bad < 10)
                            $display("FAIL rnd_result%0d: got sum=%h cvz=%b%b%b exp sum=%h cvz=%b%b%b",
                                     popped, io.Sum, io.Cout, io.V, io.Z, e.sum, e.cout, e.v, e.z);
                    end else n_pass++;
                end
                popped++;
            end
            if (io.in_valid && io.in_ready) begin
                q.push_back(ref_op(io.A, io.B, io.Cin, io.sub));
                accepted++;
            end
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        n_checks++;
        if (accepted !== n_ops || popped !== n_ops || q.size() !== 0)
            $display("FAIL rnd_count: got accepted=%0d popped=%0d pending=%0d exp %0d/%0d/0",
                     accepted, popped, q.size(), n_ops, n_ops);
        else n_pass++;
    endtask

    initial begin
        n_reset      = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.A = '0; io.B = '0; io.Cin = 1'b0; io.sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random(10000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
